// File: rtl/io_controller_pkg.sv
// Shared types and default widths for the in/out/halt sequencer.
package io_ctrl_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int SW_W_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_PRESS = 2'd1,
        CAPTURE    = 2'd2,
        HALTED     = 2'd3
    } state_t;

endpackage

// File: rtl/io_controller_if.sv
// Core-side bundle: decoder flags and register data in, stall/write-back/display out.
interface io_controller_if
    import io_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              FLAG_input;
    logic              FLAG_output;
    logic              halt;
    logic [DATA_W-1:0] rs_data;
    logic              stall;
    logic [DATA_W-1:0] input_data;
    logic              input_valid;
    logic [DATA_W-1:0] output_data;
    logic              output_valid;

    // Decoder / core side
    modport master (
        output FLAG_input, FLAG_output, halt, rs_data,
        input  stall, input_data, input_valid, output_data, output_valid
    );

    // Controller side
    modport slave (
        input  FLAG_input, FLAG_output, halt, rs_data,
        output stall, input_data, input_valid, output_data, output_valid
    );
endinterface

// File: rtl/io_controller_debouncer.sv
// Enter-button conditioning: 2-flop synchronizer, stability counter, rising-edge pulse.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             level_prev;

    // Bring the raw button into the clock domain
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a level change only after it has persisted for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            level_q    <= 1'b0;
            level_prev <= 1'b0;
        end else begin
            level_prev <= level_q;
            if (sync2 != level_q) begin
                if (cnt == CNT_MAX) begin
                    level_q <= ~level_q;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = level_q;
    assign press = level_q & ~level_prev;

endmodule

// File: rtl/io_controller.sv
// Multi-cycle sequencer for the in/out/halt instructions of the single-cycle core.
module io_controller
    import io_ctrl_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int SW_W            = SW_W_DEF,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clock,
    input  logic              reset,
    io_controller_if.slave    bus,
    input  logic [SW_W-1:0]   switches,
    input  logic              enter,
    output logic              waiting,
    output logic              halted
);
    state_t            state_q;
    state_t            state_d;
    logic [SW_W-1:0]   sw_sync1;
    logic [SW_W-1:0]   sw_sync2;
    logic              press;
    logic              enter_level;
    logic              capture_en;
    logic              out_en;
    logic              stall_c;
    logic              valid_c;
    logic              waiting_c;
    logic              halted_c;
    logic [DATA_W-1:0] input_data_q;
    logic [DATA_W-1:0] output_data_q;
    logic              output_valid_q;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter (
        .clock (clock),
        .reset (reset),
        .raw   (enter),
        .level (enter_level),
        .press (press)
    );

    // Synchronize the switch bank
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_sync1 <= '0;
            sw_sync2 <= '0;
        end else begin
            sw_sync1 <= switches;
            sw_sync2 <= sw_sync1;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Mealy outputs; stall covers the first cycle of in/halt
    always_comb begin
        state_d    = state_q;
        stall_c    = 1'b0;
        valid_c    = 1'b0;
        waiting_c  = 1'b0;
        halted_c   = 1'b0;
        capture_en = 1'b0;
        out_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.halt) begin
                    state_d = HALTED;
                    stall_c = 1'b1;
                end else if (bus.FLAG_input) begin
                    state_d = WAIT_PRESS;
                    stall_c = 1'b1;
                end else if (bus.FLAG_output) begin
                    out_en = 1'b1;
                end
            end
            WAIT_PRESS: begin
                stall_c   = 1'b1;
                waiting_c = 1'b1;
                if (press) begin
                    capture_en = 1'b1;
                    state_d    = CAPTURE;
                end
            end
            CAPTURE: begin
                valid_c = 1'b1;
                state_d = IDLE;
            end
            HALTED: begin
                stall_c  = 1'b1;
                halted_c = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Captured switch value and display register
    always_ff @(posedge clock) begin
        if (reset) begin
            input_data_q   <= '0;
            output_data_q  <= '0;
            output_valid_q <= 1'b0;
        end else begin
            if (capture_en) begin
                input_data_q <= DATA_W'(sw_sync2);
            end
            if (out_en) begin
                output_data_q  <= bus.rs_data;
                output_valid_q <= 1'b1;
            end
        end
    end

    assign bus.stall        = stall_c;
    assign bus.input_valid  = valid_c;
    assign bus.input_data   = input_data_q;
    assign bus.output_data  = output_data_q;
    assign bus.output_valid = output_valid_q;
    assign waiting          = waiting_c;
    assign halted           = halted_c;

endmodule

// File: doc/io_controller.md
Name: io_controller

Overview:
Multi-cycle sequencer for the processor's `in`, `out` and `halt` instructions.
- `in`: stalls the single-cycle core until the user presses the enter button, then hands the captured switch value to the write-back path for exactly one cycle.
- `out`: latches R[rs] into a display register.
- `halt`: parks the machine in a terminal state.
- Placement: between the instruction decoder (FLAG_input, FLAG_output, halt) and the PC / register-file write enables.

Parameters:
- DATA_W, 32, datapath word width.
- SW_W, 16, switch bank width (must be ≤ DATA_W).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a button level change.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- FLAG_input  in  1  decoder: current instruction is `in`.
- FLAG_output  in  1  decoder: current instruction is `out`.
- halt  in  1  decoder: current instruction is `halt`.
- rs_data  in  DATA_W  R[rs] from the register file.
- switches  in  SW_W  raw asynchronous switch bank.
- enter  in  1  raw asynchronous push button, active-high.
- stall  out  1  freezes the PC; top level gates FLAG_register with !stall.
- input_data  out  DATA_W  zero-extended captured switches, feeds MUX_write input 3.
- input_valid  out  1  single-cycle pulse; the core commits `in` on this cycle.
- output_data  out  DATA_W  latched display value.
- output_valid  out  1  high from the first executed `out` until reset.
- waiting  out  1  status LED: waiting for the user.
- halted  out  1  machine halted.

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs 0. Synchronizers, debounced level, debounce counter and switch capture register all cleared. Reset has priority over every event, including mid-WAIT_PRESS; stall drops on the cycle after the reset edge.
- Input conditioning:
  - enter and switches each pass through a 2-flop synchronizer.
  - Debounce: the counter increments while the synced enter differs from the debounced level, and clears on any match. When the count reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level toggles and the counter clears.
  - press = rising edge of the debounced level, one cycle wide.
- FSM states: IDLE, WAIT_PRESS, CAPTURE, HALTED.
- IDLE:
  - halt → HALTED (halt takes priority over the flags).
  - else FLAG_input → WAIT_PRESS.
  - else FLAG_output → output_data <= rs_data and output_valid <= 1 at the edge; no stall.
- WAIT_PRESS:
  - waiting=1.
  - On press, capture the synced switches into input_data (zero-extended) and go to CAPTURE.
  - A press seen while in IDLE or CAPTURE is discarded, never queued.
- CAPTURE:
  - input_valid=1, stall=0; the PC advances and R[rd] is written at this edge.
  - → IDLE unconditionally. FLAG_input still high here belongs to the same instruction and is ignored.
- HALTED:
  - stall=1, halted=1.
  - FLAG_input, FLAG_output and press are ignored; exit only via reset.
- stall is Mealy: stall = (IDLE & (FLAG_input | halt)) | WAIT_PRESS | HALTED. This guarantees the PC never advances on the first cycle of an `in` or `halt`.
- Latency: `in` completes 1 cycle after press detection. Minimum total `in` duration is 3 cycles (IDLE, WAIT_PRESS, CAPTURE). The synchronizer plus debounce path adds 2+DEBOUNCE_CYCLES cycles from the raw button.
- input_data holds its value until the next capture. output_data holds until the next `out`.
- Back-to-back `in` instructions each require a separate release and press. A button held across CAPTURE produces no second press.

Decomposition:
- Package io_ctrl_pkg: state enum (IDLE, WAIT_PRESS, CAPTURE, HALTED) and the DATA_W/SW_W default constants.
- Sub-module button_debouncer: synchronizer, debounce counter and rising-edge detector. Ports: clock, reset, raw, level, press. Parameter: DEBOUNCE_CYCLES.

Test Plan (simulate with DEBOUNCE_CYCLES=4):
- Reset then idle, no flags → stall=0, input_valid=0, output_valid=0, output_data=0, halted=0.
- FLAG_input=1, switches=16'hA5C3, enter held high 10 cycles → stall=1 from the first cycle. input_valid pulses once, input_data=32'h0000A5C3, then stall=0.
- FLAG_input=1, enter glitches high for 2 cycles only → no press, stall stays 1, input_valid never asserts.
- FLAG_output=1, rs_data=32'hDEADBEEF → next cycle output_data=32'hDEADBEEF, output_valid=1, stall=0 throughout.
- Press enter while IDLE, then assert FLAG_input with enter still held → remains in WAIT_PRESS until release and re-press; exactly one input_valid.
- halt=1, then FLAG_input/FLAG_output pulses → stall=1 and halted=1 persist, output_data unchanged. Reset asserted mid-WAIT_PRESS → IDLE, stall=0 next cycle.
